mem_burst_ctrl: RTL
===================

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, memory word-address width (32 words).
REQ-002 Parameter DATA_W, default 32, memory word width.
REQ-003 Parameter LEN_W, default 6, burst-length field width (legal length 1..32).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  burst command offered.
REQ-007 cmd_ready  output  1  controller accepts a command (high only in IDLE).
REQ-008 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  input  ADDR_W  burst start word address.
REQ-010 cmd_len  input  LEN_W  word count.
REQ-011 wr_valid / wr_ready / wr_data  input / output / input  1 / 1 / DATA_W  write-data stream.
REQ-012 rd_valid / rd_ready / rd_data  output / input / output  1 / 1 / DATA_W  read-data stream.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 err  output  1  one-cycle pulse on rejected command.
REQ-015 mem_address  output  ADDR_W  memory word address.
REQ-016 mem_in  output  DATA_W  data to memory.
REQ-017 mem_out  input  DATA_W  combinational memory read data.
REQ-018 mem_read  output  1  drives the memory "read" pin: 0 = memory reads (output follows address), 1 = memory writes mem_in (level-sensitive).

Function
REQ-019 The FSM SHALL have states IDLE, RD_ISSUE, RD_HOLD, WR_WAIT, WR_SETUP, WR_STROBE.
REQ-020 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both high; address, length and direction are latched then.
REQ-021 An accepted command with cmd_len = 0 or cmd_len > 32 SHALL pulse err for one cycle, perform no memory access and stay in IDLE.
REQ-022 IDLE -> RD_ISSUE on an accepted legal read; IDLE -> WR_WAIT on an accepted legal write.
REQ-023 RD_ISSUE SHALL drive mem_address = current address with mem_read = 0, register mem_out into rd_data at the end of the cycle, and go to RD_HOLD.
REQ-024 RD_HOLD SHALL hold rd_valid high and rd_data stable until rd_ready; on rd_valid && rd_ready, next is RD_ISSUE if words remain, else IDLE.
REQ-025 Read latency: rd_valid rises 2 cycles after command acceptance; sustained rate is 1 word per 2 cycles with rd_ready held high.
REQ-026 WR_WAIT SHALL assert wr_ready; on wr_valid && wr_ready, wr_data is latched into mem_in and next is WR_SETUP.
REQ-027 WR_SETUP SHALL drive mem_address and mem_in stable with mem_read = 0 for one cycle, then go to WR_STROBE.
REQ-028 WR_STROBE SHALL drive mem_read = 1 for exactly one cycle with mem_address and mem_in unchanged, then go to WR_WAIT if words remain, else IDLE.
REQ-029 mem_address and mem_in SHALL never change in a cycle where mem_read = 1, nor in the cycle immediately following one.
REQ-030 The word address SHALL increment by 1 after each word, wrapping 31 -> 0 (modulo 2^ADDR_W).
REQ-031 The remaining-word counter SHALL load cmd_len on acceptance and decrement by 1 per completed word; the burst ends when it reaches 0.
REQ-032 mem_read SHALL be 0 in every state except WR_STROBE; wr_ready SHALL be high only in WR_WAIT; rd_valid only in RD_HOLD.

Reset
REQ-033 On reset the FSM SHALL enter IDLE immediately and all outputs SHALL be 0 (mem_read, rd_valid, wr_ready, busy, err, rd_data, mem_in, mem_address), except cmd_ready, which SHALL be 1 once reset deasserts.
REQ-034 Reset during WR_STROBE SHALL drop mem_read asynchronously; the in-flight word is not guaranteed written; the remainder of the burst is abandoned.

Structure
REQ-035 A shared package SHALL hold the FSM state enumeration and the ADDR_W/DATA_W/LEN_W defaults.
REQ-036 The address/remaining-count logic SHALL be one sub-module, burst_addr_gen (load, step, wrap, last flag).

Verification
REQ-037 Read burst addr=3, len=4, rd_ready always high, memory preloaded mem[k]=k -> rd_data 3,4,5,6 with rd_valid rising at cycles 2,4,6,8 after acceptance; then IDLE.
REQ-038 Write burst addr=30, len=4, data A0..A3 -> memory words 30,31,0,1 hold A0..A3; exactly 4 one-cycle mem_read pulses, each with address/data stable one cycle before and after.
REQ-039 Read burst len=2 with rd_ready low for 5 cycles on word 1 -> rd_valid held and rd_data stable throughout; no new memory address issued until the handshake.
REQ-040 Commands with cmd_len=0 and cmd_len=33 -> one-cycle err each, mem_read never asserted, busy stays 0.
REQ-041 Reset asserted mid-write burst (in WR_STROBE of word 2 of 4) -> mem_read 0 in the same cycle, outputs zero, cmd_ready=1 in the first cycle after release; a subsequent read burst of len=1 completes normally.
REQ-042 cmd_valid held high while busy -> cmd_ready 0 and no second command latched until IDLE.

Source files
------------

// File: rtl/mem_burst_ctrl_pkg.sv
// Shared definitions for the burst memory controller: FSM states and width defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_burst_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 6;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_HOLD,
    WR_WAIT,
    WR_SETUP,
    WR_STROBE
  } state_t;

endpackage

// File: rtl/mem_burst_ctrl_addr_gen.sv
// Burst address / remaining-word tracker: loads start address and length, steps per word.
// Latency: registered, new values visible the cycle after load/step.
// Backpressure: none; step is only honoured while words remain.
module burst_addr_gen
  import mem_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [LEN_W-1:0]  ONE_L = 1;

  logic [LEN_W-1:0] remaining;

  // Address wraps naturally at 2^ADDR_W.
  assign next_addr = addr + ONE_A;
  assign last      = (remaining == ONE_L);

  // Load on command acceptance, advance one word per completed transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step && (remaining != '0)) begin
      addr      <= next_addr;
      remaining <= remaining - ONE_L;
    end
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst read/write controller in front of a single-port word memory with a level-sensitive write pin.
// Latency: read data valid 2 cycles after command accept, 1 word per 2 cycles; writes take 3 cycles per word.
// Backpressure: cmd_ready only in IDLE; rd_valid held until rd_ready; wr_ready only while waiting for a word.
module mem_burst_ctrl
  import mem_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              mem_read
);

  // Longest legal burst covers the whole address space once.
  localparam logic [31:0] MAX_LEN = 32'(1) << ADDR_W;

  state_t            state;
  logic              accept;
  logic              cmd_ok;
  logic              gen_load;
  logic              gen_step;
  logic [ADDR_W-1:0] gen_addr;
  logic [ADDR_W-1:0] gen_next_addr;
  logic              gen_last;

  // Handshake outputs are straight decodes of the state register, so they
  // drop together with the state on an asynchronous reset.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WR_WAIT);
  assign rd_valid  = (state == RD_HOLD);
  assign mem_read  = (state == WR_STROBE);

  assign accept   = cmd_valid && cmd_ready;
  assign cmd_ok   = (cmd_len != '0) && (32'(cmd_len) <= MAX_LEN);
  assign gen_load = accept && cmd_ok;
  assign gen_step = (rd_valid && rd_ready) || (state == WR_STROBE);

  burst_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (gen_load),
    .load_addr(cmd_addr),
    .load_len (cmd_len),
    .step     (gen_step),
    .addr     (gen_addr),
    .next_addr(gen_next_addr),
    .last     (gen_last)
  );

  // Burst sequencing. mem_address only moves when entering RD_ISSUE or
  // WR_SETUP, so it stays put through a strobe and the cycle after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      err         <= 1'b0;
      rd_data     <= '0;
      mem_in      <= '0;
      mem_address <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!cmd_ok) begin
              err <= 1'b1;
            end else if (cmd_write) begin
              state <= WR_WAIT;
            end else begin
              state       <= RD_ISSUE;
              mem_address <= cmd_addr;
            end
          end
        end
        RD_ISSUE: begin
          rd_data <= mem_out;
          state   <= RD_HOLD;
        end
        RD_HOLD: begin
          if (rd_ready) begin
            if (gen_last) begin
              state <= IDLE;
            end else begin
              state       <= RD_ISSUE;
              mem_address <= gen_next_addr;
            end
          end
        end
        WR_WAIT: begin
          if (wr_valid) begin
            mem_in      <= wr_data;
            mem_address <= gen_addr;
            state       <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          state <= WR_STROBE;
        end
        WR_STROBE: begin
          state <= gen_last ? IDLE : WR_WAIT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
